// File: rtl/fifo_sync_param.sv
// Synchronous FIFO with op-tracking FSM; write visible to a read one edge later, read data registered with rd_ack.
// No backpressure: rejected requests raise wr_err/rd_err for one cycle and leave contents untouched.
module fifo_sync_param #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic [2:0]        state,
  output logic [$clog2(DEPTH):0] data_count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              rd_ack,
  output logic              rd_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    INIT   = 3'b000,
    WRITE  = 3'b001,
    WR_ERR = 3'b010,
    NO_OP  = 3'b011,
    READ   = 3'b100,
    RD_ERR = 3'b101,
    WR_RD  = 3'b110
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     head, tail;
  logic [2:0]        state_r;
  state_t            state_nxt;
  logic              do_wr, do_rd;
  logic              wr_ack_nxt, wr_err_nxt, rd_ack_nxt, rd_err_nxt;

  assign state        = state_r;
  assign full         = (data_count == CW'(DEPTH));
  assign empty        = (data_count == '0);
  assign almost_full  = (data_count >= CW'(AF_THRESH));
  assign almost_empty = (data_count <= CW'(AE_THRESH));

  always_comb begin
    state_nxt  = NO_OP;
    do_wr      = 1'b0;
    do_rd      = 1'b0;
    wr_ack_nxt = 1'b0;
    wr_err_nxt = 1'b0;
    rd_ack_nxt = 1'b0;
    rd_err_nxt = 1'b0;
    if (clear) begin
      state_nxt = INIT;
    end else if (state_r == 3'b111) begin
      // Illegal encoding: return to INIT without touching pointers or count.
      state_nxt = INIT;
    end else begin
      case ({wr_en, rd_en})
        2'b10: begin
          if (full) begin
            state_nxt  = WR_ERR;
            wr_err_nxt = 1'b1;
          end else begin
            state_nxt  = WRITE;
            do_wr      = 1'b1;
            wr_ack_nxt = 1'b1;
          end
        end
        2'b01: begin
          if (empty) begin
            state_nxt  = RD_ERR;
            rd_err_nxt = 1'b1;
          end else begin
            state_nxt  = READ;
            do_rd      = 1'b1;
            rd_ack_nxt = 1'b1;
          end
        end
        2'b11: begin
          // When empty only the write lands; no fall-through of din to dout.
          if (empty) begin
            state_nxt  = WRITE;
            do_wr      = 1'b1;
            wr_ack_nxt = 1'b1;
            rd_err_nxt = 1'b1;
          end else begin
            state_nxt  = WR_RD;
            do_wr      = 1'b1;
            do_rd      = 1'b1;
            wr_ack_nxt = 1'b1;
            rd_ack_nxt = 1'b1;
          end
        end
        default: state_nxt = NO_OP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[tail] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= INIT;
      head       <= '0;
      tail       <= '0;
      data_count <= '0;
      dout       <= '0;
      wr_ack     <= 1'b0;
      wr_err     <= 1'b0;
      rd_ack     <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      state_r <= state_nxt;
      wr_ack  <= wr_ack_nxt;
      wr_err  <= wr_err_nxt;
      rd_ack  <= rd_ack_nxt;
      rd_err  <= rd_err_nxt;
      if (clear) begin
        head       <= '0;
        tail       <= '0;
        data_count <= '0;
      end else begin
        if (do_wr) tail <= tail + AW'(1);
        if (do_rd) begin
          head <= head + AW'(1);
          dout <= mem[head];
        end
        case ({do_wr, do_rd})
          2'b10:   data_count <= data_count + CW'(1);
          2'b01:   data_count <= data_count - CW'(1);
          default: data_count <= data_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param at DATA_W=32, DEPTH=8, AF=6, AE=2.
module tb_fifo_sync_param;

  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clear;
  logic          wr_en;
  logic [DW-1:0] din;
  logic          rd_en;
  logic [DW-1:0] dout;
  logic [2:0]    state;
  logic [3:0]    data_count;
  logic          full, empty, almost_full, almost_empty;
  logic          wr_ack, wr_err, rd_ack, rd_err;

  fifo_sync_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .wr_en(wr_en), .din(din),
    .rd_en(rd_en), .dout(dout), .state(state), .data_count(data_count),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] sb[$];
  logic [DW-1:0] exp_dout;
  logic [2:0]    exp_state;
  logic          exp_wack, exp_werr, exp_rack, exp_rerr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string where);
    int n;
    n = sb.size();
    chk({where, ":state"}, 32'(state), 32'(exp_state));
    chk({where, ":count"}, 32'(data_count), n);
    chk({where, ":full"}, 32'(full), 32'(n == DEPTH));
    chk({where, ":empty"}, 32'(empty), 32'(n == 0));
    chk({where, ":afull"}, 32'(almost_full), 32'(n >= AF));
    chk({where, ":aempty"}, 32'(almost_empty), 32'(n <= AE));
    chk({where, ":wack"}, 32'(wr_ack), 32'(exp_wack));
    chk({where, ":werr"}, 32'(wr_err), 32'(exp_werr));
    chk({where, ":rack"}, 32'(rd_ack), 32'(exp_rack));
    chk({where, ":rerr"}, 32'(rd_err), 32'(exp_rerr));
    chk({where, ":dout"}, dout, exp_dout);
  endtask

  task automatic model_reset();
    sb.delete();
    exp_dout  = '0;
    exp_state = 3'b000;
    exp_wack  = 1'b0;
    exp_werr  = 1'b0;
    exp_rack  = 1'b0;
    exp_rerr  = 1'b0;
  endtask

  task automatic step(input string where, input logic w, input logic r,
                      input logic clr, input logic [DW-1:0] d);
    int n;
    @(negedge clk);
    wr_en = w; rd_en = r; clear = clr; din = d;
    n = sb.size();
    exp_wack = 1'b0; exp_werr = 1'b0; exp_rack = 1'b0; exp_rerr = 1'b0;
    if (clr) begin
      sb.delete();
      exp_state = 3'b000;
    end else if (w && !r) begin
      if (n == DEPTH) begin exp_state = 3'b010; exp_werr = 1'b1; end
      else begin sb.push_back(d); exp_state = 3'b001; exp_wack = 1'b1; end
    end else if (!w && r) begin
      if (n == 0) begin exp_state = 3'b101; exp_rerr = 1'b1; end
      else begin exp_dout = sb.pop_front(); exp_state = 3'b100; exp_rack = 1'b1; end
    end else if (w && r) begin
      if (n == 0) begin
        sb.push_back(d); exp_state = 3'b001; exp_wack = 1'b1; exp_rerr = 1'b1;
      end else begin
        exp_dout = sb.pop_front(); sb.push_back(d);
        exp_state = 3'b110; exp_wack = 1'b1; exp_rack = 1'b1;
      end
    end else begin
      exp_state = 3'b011;
    end
    @(posedge clk);
    #1;
    check_all(where);
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    reset_n = 1'b1;

    step("idle0", 0, 0, 0, '0);
    step("idle1", 0, 0, 0, '0);

    for (int k = 1; k <= 8; k++) step($sformatf("fill%0d", k), 1, 0, 0, 32'(k * 'h11));
    step("wr_full", 1, 0, 0, 32'h99);

    for (int k = 1; k <= 9; k++) step($sformatf("drain%0d", k), 0, 1, 0, '0);

    for (int k = 0; k < 5; k++) step("wrap_w5", 1, 0, 0, 32'h50 + 32'(k));
    for (int k = 0; k < 5; k++) step("wrap_r5", 0, 1, 0, '0);
    for (int k = 0; k < 6; k++) step("wrap_w6", 1, 0, 0, 32'hA0 + 32'(k));
    for (int k = 0; k < 6; k++) step("wrap_r6", 0, 1, 0, '0);

    step("both_empty", 1, 1, 0, 32'h55);
    for (int k = 0; k < 7; k++) step("refill", 1, 0, 0, 32'hC0 + 32'(k));
    step("both_full", 1, 1, 0, 32'hDD);
    step("both_full2", 1, 1, 0, 32'hDE);

    for (int k = 0; k < 4; k++) step("to4", 0, 1, 0, '0);
    step("clear_wr", 1, 0, 1, 32'hEE);
    step("after_clr", 0, 1, 0, '0);

    for (int k = 0; k < 3; k++) step("pre_rst", 1, 0, 0, 32'hF0 + 32'(k));
    #2;
    reset_n = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    reset_n = 1'b1;

    for (int k = 0; k < 300; k++) begin
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 39) == 0), $urandom());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
